seg7_scan_sched: RTL
====================

// Module: seg7_scan_sched
// PURPOSE
//  Time-multiplexed scan scheduler for a common-anode multi-digit 7-segment display.
//  Shares one hex-to-7seg decoder (4-bit digit in, 7-bit active-low segments out) among NDIG digits.
//  Holds a tear-free shadow copy of the displayed value and handles leading-zero blanking and per-digit blink.
//  Sits between the debug/status registers and the decoder; the decoder output drives the segment pins directly.
// PARAMETERS
//  NDIG      4     number of digits scanned (2..8)
//  DIV       1000  m_clock cycles per digit slot, including the blank guard (> BLANK)
//  BLANK     16    guard cycles at the start of each slot; all anodes off (anti-ghosting)
//  BLINK_FR  64    frames per blink half-period
// PORTS
//  m_clock  in   1       system clock, rising edge
//  p_reset  in   1       asynchronous, active-low reset
//  iVAL     in   4*NDIG  value to display; nibble i = digit i, digit 0 is least significant
//  iLOAD    in   1       request to capture iVAL; sampled only when oBUSY=0
//  iLZB     in   1       leading-zero blank enable (live)
//  iBLINK   in   NDIG    per-digit blink mask (live)
//  oDIG     out  4       nibble to the shared decoder (registered)
//  oDIG_EN  out  NDIG    anode enables, active-low, at most one bit low (registered)
//  oBUSY    out  1       capture pending; high until the next frame boundary
//  oFRAME   out  1       1-cycle pulse at the start of slot 0 of each frame
// BEHAVIOUR
//  Reset (p_reset=0, async): cnt=0, idx=0, shadow=0, pend=0, phase=0, frcnt=0,
//   oDIG=0, oDIG_EN=all 1, oBUSY=0, oFRAME=0. Release: scan restarts at idx 0, cnt 0.
//   Reset mid-frame aborts the frame and drops any pending capture.
//  Slot counter cnt: 0..DIV-1, then wraps to 0 and idx advances. idx wraps from NDIG-1 to 0.
//  Frame boundary: cnt=DIV-1 and idx=NDIG-1.
//  State per slot: GUARD (cnt<BLANK) -> ON (cnt>=BLANK).
//   GUARD: oDIG_EN = all 1.
//   ON: oDIG_EN[idx]=0 unless the digit is suppressed.
//  Outputs are registered: oDIG/oDIG_EN reflect cnt/idx of the previous cycle (1-cycle latency).
//  oDIG = shadow nibble idx during both GUARD and ON; decoder settles during GUARD.
//  Capture handshake:
//   iLOAD=1 with oBUSY=0 -> stage iVAL, pend=1, oBUSY=1 next cycle.
//   iLOAD while oBUSY=1 is ignored (staging register unchanged).
//   At the frame boundary with pend=1: shadow<=staged, pend=0, oBUSY=0 next cycle.
//   Display therefore never mixes old and new digits within a frame.
//   iLOAD on the boundary cycle itself with oBUSY=0: staged, applied at the NEXT boundary.
//  Leading-zero blank (iLZB=1): digit i>0 is suppressed if shadow nibbles i..NDIG-1 are all 0.
//   Digit 0 is never LZB-suppressed; value 0 shows a single "0".
//  Blink: frcnt counts frames 0..BLINK_FR-1; phase toggles on wrap.
//   phase=1 suppresses digit i if iBLINK[i]=1.
//  Suppressed digit: oDIG_EN stays all 1 for that whole slot; slot timing unchanged.
//  oFRAME=1 for exactly the cycle after each frame boundary (aligned with cnt=0, idx=0).
//  Widths: cnt = clog2(DIV), idx = clog2(NDIG), frcnt = clog2(BLINK_FR); all wrap explicitly, no overflow.
// TESTING
//  1 Reset, NDIG=4 DIV=20 BLANK=4, shadow=0, iLZB=0 -> oDIG_EN low pattern 1110,1101,1011,0111;
//    each anode low 16 cycles, preceded by a 4-cycle all-1 guard; oFRAME pulses every 80 cycles.
//  2 iLOAD, iVAL=16'h1234, mid-frame -> oBUSY=1 until the boundary; next frame shows 4,3,2,1 on digits 0..3;
//    no frame mixes old and new nibbles.
//  3 iLOAD again while oBUSY=1 with iVAL=16'hFFFF -> ignored; display becomes 1234 only.
//  4 iLZB=1, load 16'h0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0;
//    load 16'h0000 -> only digit 0 lit.
//  5 BLINK_FR=2, iBLINK=4'b0001 -> digit 0 dark for 2 frames then lit for 2 frames, repeating;
//    the other digits are always lit.
//  6 Assert p_reset mid-slot with a capture pending -> oDIG_EN=all 1 and oBUSY=0 immediately (async);
//    after release, shadow=0 and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_sched.sv
// Scan scheduler for a common-anode multi-digit 7-segment display sharing one decoder.
// Holds a frame-aligned shadow of the value, with leading-zero blanking and per-digit blink.
module seg7_scan_sched #(
  parameter int unsigned NDIG     = 4,
  parameter int unsigned DIV      = 1000,
  parameter int unsigned BLANK    = 16,
  parameter int unsigned BLINK_FR = 64
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic [4*NDIG-1:0] iVAL,
  input  logic              iLOAD,
  input  logic              iLZB,
  input  logic [NDIG-1:0]   iBLINK,
  output logic [3:0]        oDIG,
  output logic [NDIG-1:0]   oDIG_EN,
  output logic              oBUSY,
  output logic              oFRAME
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned FrW  = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NDIG - 1);
  localparam logic [FrW-1:0]  FrLast   = FrW'(BLINK_FR - 1);

  logic [CntW-1:0]   r_cnt;
  logic [IdxW-1:0]   r_idx;
  logic [4*NDIG-1:0] r_shadow;
  logic [4*NDIG-1:0] r_stage;
  logic              r_pend;
  logic              r_phase;
  logic [FrW-1:0]    r_frcnt;
  logic [3:0]        r_dig;
  logic [NDIG-1:0]   r_dig_en;
  logic              r_frame;

  logic [3:0]        w_nib [NDIG];
  logic [NDIG-1:0]   w_nz;
  logic              w_bound;
  logic              w_on;
  logic              w_sup;
  logic [NDIG-1:0]   w_en_next;

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      w_nib[i] = r_shadow[4*i +: 4];
      w_nz[i]  = |r_shadow[4*i +: 4];
    end
  end

  assign w_bound = (r_cnt == CntLast) && (r_idx == IdxLast);
  assign w_on    = (r_cnt >= CntBlank);

  // Digit i>0 is leading-zero blanked when nibbles i..NDIG-1 are all zero.
  assign w_sup = (iLZB && (r_idx != '0) && !(|(w_nz >> r_idx))) ||
                 (r_phase && iBLINK[r_idx]);

  always_comb begin
    w_en_next = '1;
    if (w_on && !w_sup) begin
      w_en_next[r_idx] = 1'b0;
    end
  end

  // Slot/digit scan counters.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CntLast) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Capture handshake: shadow only changes at a frame boundary, so a frame never mixes values.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_stage  <= '0;
      r_shadow <= '0;
      r_pend   <= 1'b0;
    end else if (iLOAD && !r_pend) begin
      r_stage <= iVAL;
      r_pend  <= 1'b1;
    end else if (w_bound && r_pend) begin
      r_shadow <= r_stage;
      r_pend   <= 1'b0;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_frcnt <= '0;
      r_phase <= 1'b0;
    end else if (w_bound) begin
      if (r_frcnt == FrLast) begin
        r_frcnt <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frcnt <= r_frcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_dig    <= 4'h0;
      r_dig_en <= '1;
      r_frame  <= 1'b0;
    end else begin
      r_dig    <= w_nib[r_idx];
      r_dig_en <= w_en_next;
      r_frame  <= w_bound;
    end
  end

  assign oDIG    = r_dig;
  assign oDIG_EN = r_dig_en;
  assign oBUSY   = r_pend;
  assign oFRAME  = r_frame;

endmodule
